// File: rtl/riscuin_core_sequencer.sv
// rtl/riscuin_core_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM for the RISCuin core
module riscuin_core_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rb_ready,
  input  logic             pc_end,
  input  logic             halt_req,
  input  logic             dec_reg_w,
  input  logic             dec_mem_r,
  input  logic             dec_mem_w,
  input  logic             dec_branch,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             alu_en,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_w,
  output logic             pc_en,
  output logic             pc_src,
  output logic             halted,
  output logic             bus_fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  state_t          state, state_nxt;
  logic            f_reg_w, f_mem_r, f_mem_w, f_branch;
  logic [TW-1:0]   tmo_cnt;
  logic            timeout;

  // Last allowed MEM cycle: a missing ack here means the bus never answered.
  assign timeout = (tmo_cnt == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      f_reg_w     <= 1'b0;
      f_mem_r     <= 1'b0;
      f_mem_w     <= 1'b0;
      f_branch    <= 1'b0;
      tmo_cnt     <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        f_reg_w  <= dec_reg_w;
        f_mem_r  <= dec_mem_r;
        f_mem_w  <= dec_mem_w;
        f_branch <= dec_branch;
      end
      if (state == S_EXEC)
        tmo_cnt <= '0;
      else if (state == S_MEM && !mem_ack)
        tmo_cnt <= tmo_cnt + TW'(1);
      if (state == S_WB && instr_count != {CNT_W{1'b1}})
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rb_ready) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (f_mem_r && f_mem_w)      state_nxt = S_FAULT;
        else if (f_mem_r || f_mem_w) state_nxt = S_MEM;
        else                         state_nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ack)      state_nxt = S_WB;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_WB:     state_nxt = (pc_end || halt_req) ? S_HALT : S_FETCH;
      default:  state_nxt = state;
    endcase
    // Losing the register bank aborts whatever instruction is in flight.
    if (!rb_ready && state inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB})
      state_nxt = S_IDLE;
  end

  assign ir_load   = (state == S_FETCH);
  assign alu_en    = (state == S_EXEC);
  assign mem_rd    = (state == S_MEM) && f_mem_r;
  assign mem_wr    = (state == S_MEM) && f_mem_w;
  assign reg_w     = (state == S_WB) && f_reg_w && !f_mem_w;
  assign pc_en     = (state == S_WB);
  assign pc_src    = (state == S_WB) && f_branch;
  assign halted    = (state == S_HALT);
  assign bus_fault = (state == S_FAULT);

endmodule

// File: tb/tb_riscuin_core_sequencer.sv
// tb/tb_riscuin_core_sequencer.sv - randomized instruction-level check of riscuin_core_sequencer
module tb_riscuin_core_sequencer;

  localparam int T  = 15;
  localparam int CW = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic rb_ready = 0, pc_end = 0, halt_req = 0;
  logic dec_reg_w = 0, dec_mem_r = 0, dec_mem_w = 0, dec_branch = 0, mem_ack = 0;
  logic ir_load, alu_en, mem_rd, mem_wr, reg_w, pc_en, pc_src, halted, bus_fault;
  logic [CW-1:0] instr_count;

  riscuin_core_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rb_ready(rb_ready), .pc_end(pc_end), .halt_req(halt_req),
    .dec_reg_w(dec_reg_w), .dec_mem_r(dec_mem_r), .dec_mem_w(dec_mem_w),
    .dec_branch(dec_branch), .mem_ack(mem_ack), .ir_load(ir_load), .alu_en(alu_en),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_w(reg_w), .pc_en(pc_en), .pc_src(pc_src),
    .halted(halted), .bus_fault(bus_fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] O_IR = 9'h100, O_ALU = 9'h080, O_RD = 9'h040, O_WR = 9'h020,
                         O_RW = 9'h010, O_PC = 9'h008, O_SRC = 9'h004, O_HLT = 9'h002,
                         O_FLT = 9'h001;

  wire [8:0] obs = {ir_load, alu_en, mem_rd, mem_wr, reg_w, pc_en, pc_src, halted, bus_fault};

  int errs = 0, checks = 0;
  int mcount = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check the current cycle's outputs, then move one clock on.
  task automatic cyc(input logic [8:0] exp, input string tag);
    check(tag, 32'(obs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  // Decoder/bus/halt inputs are noise outside the states that sample them.
  task automatic garbage();
    dec_reg_w  = 1'($urandom); dec_mem_r = 1'($urandom);
    dec_mem_w  = 1'($urandom); dec_branch = 1'($urandom);
    mem_ack    = 1'($urandom); pc_end = 1'($urandom); halt_req = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; rb_ready = 1'b0;
    #1;
    check("reset_outs", 32'(obs), 32'h0);
    check("reset_count", 32'(instr_count), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mcount = 0;
  endtask

  task automatic start();
    rb_ready = 1'b1; garbage();
    cyc(9'h0, "idle_to_fetch");
  endtask

  // stop: 0 continue, 1 pc_end in WB, 2 halt_req in WB. ack_at outside 1..T means no ack.
  task automatic do_instr(input bit rw, input bit r, input bit w, input bit b,
                          input int ack_at, input int stop);
    garbage(); cyc(O_IR, "fetch");
    garbage();
    dec_reg_w = rw; dec_mem_r = r; dec_mem_w = w; dec_branch = b;
    cyc(9'h0, "decode");
    garbage(); cyc(O_ALU, "exec");
    if (r && w) begin
      for (int i = 0; i < 3; i++) begin garbage(); cyc(O_FLT, "illegal_fault"); end
      return;
    end
    if (r || w) begin
      for (int k = 1; k <= T; k++) begin
        garbage(); mem_ack = (k == ack_at);
        cyc((r ? O_RD : 9'h0) | (w ? O_WR : 9'h0), "mem");
        if (k == ack_at) break;
      end
      if (ack_at < 1 || ack_at > T) begin
        for (int i = 0; i < 3; i++) begin garbage(); cyc(O_FLT, "timeout_fault"); end
        check("fault_count", 32'(instr_count), 32'(mcount));
        return;
      end
    end
    garbage(); pc_end = (stop == 1); halt_req = (stop == 2);
    cyc(O_PC | ((rw && !w) ? O_RW : 9'h0) | (b ? O_SRC : 9'h0), "wb");
    if (mcount < (1 << CW) - 1) mcount++;
    check("count", 32'(instr_count), 32'(mcount));
    if (stop != 0)
      for (int i = 0; i < 3; i++) begin garbage(); cyc(O_HLT, "halt"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r, w;
    int kind;
    #3;
    check("reset_outs_async", 32'(obs), 32'h0);
    check("reset_count_async", 32'(instr_count), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin garbage(); cyc(9'h0, "idle_wait"); end
    start();

    for (int i = 0; i < 10; i++) do_instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    check("count_after_10", 32'(instr_count), 32'd10);

    do_instr(1'b1, 1'b1, 1'b0, 1'b0, 3, 0);
    do_instr(1'b1, 1'b0, 1'b1, 1'b0, 1, 0);
    do_instr(1'b0, 1'b0, 1'b1, 1'b0, T, 0);

    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 2));
      r = (kind == 1); w = (kind == 2);
      do_instr(1'($urandom), r, w, 1'($urandom), int'($urandom_range(1, T)), 0);
    end
    check("count_saturated", 32'(instr_count), 32'((1 << CW) - 1));

    do_instr(1'b1, 1'b0, 1'b0, 1'b1, 0, 1);

    do_reset(); start();
    do_instr(1'b0, 1'b0, 1'b0, 1'b0, 0, 2);

    do_reset(); start();
    do_instr(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

    do_reset(); start();
    do_instr(1'b1, 1'b1, 1'b1, 1'b0, 1, 0);

    do_reset(); start();
    garbage(); cyc(O_IR, "abort_fetch");
    garbage(); dec_reg_w = 1; dec_mem_r = 1; dec_mem_w = 0; dec_branch = 0;
    cyc(9'h0, "abort_decode");
    garbage(); cyc(O_ALU, "abort_exec");
    for (int k = 0; k < 2; k++) begin garbage(); mem_ack = 0; cyc(O_RD, "abort_mem"); end
    garbage(); mem_ack = 0; rb_ready = 0;
    cyc(O_RD, "abort_mem_drop");
    for (int i = 0; i < 3; i++) begin garbage(); cyc(9'h0, "abort_idle"); end
    check("abort_count", 32'(instr_count), 32'h0);
    start();
    do_instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    garbage(); cyc(O_IR, "rst_fetch");
    garbage(); cyc(9'h0, "rst_decode");
    garbage();
    check("rst_exec_pre", 32'(obs), 32'(O_ALU));
    rst = 1'b1;
    #1;
    check("rst_mid_exec_outs", 32'(obs), 32'h0);
    check("rst_mid_exec_count", 32'(instr_count), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rb_ready = 1'b0; mcount = 0;
    garbage(); cyc(9'h0, "post_rst_idle");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
